// File: rtl/edge_filter_pkg.sv
// Shared defaults for the multi-channel edge filter.
package edge_filter_pkg;

  localparam int EF_CNT_W       = 4;
  localparam int EF_SYNC_STAGES = 2;

  typedef logic [EF_CNT_W-1:0] ef_cnt_t;

endpackage

// File: rtl/edge_filter_chan.sv
// One filter channel: input synchronizer, stable-count debouncer, registered level and ticks.
module edge_filter_chan
  import edge_filter_pkg::*;
#(
  parameter int   CNT_W       = EF_CNT_W,
  parameter int   SYNC_STAGES = EF_SYNC_STAGES,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  input  logic             enable,
  input  logic [CNT_W-1:0] threshold,
  output logic             level,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             glitch_tick
);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       thr_m1;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // A threshold of 0 behaves like 1, so the flip point is thr-1 with a floor of 0.
  assign thr_m1 = (threshold == '0) ? '0 : threshold - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync        <= {SYNC_STAGES{RESET_LEVEL}};
      level       <= RESET_LEVEL;
      cnt         <= '0;
      rise_tick   <= 1'b0;
      fall_tick   <= 1'b0;
      glitch_tick <= 1'b0;
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], d};
      rise_tick   <= 1'b0;
      fall_tick   <= 1'b0;
      glitch_tick <= 1'b0;
      if (!enable) begin
        cnt <= '0;
      end else if (s == level) begin
        if (cnt != '0) glitch_tick <= 1'b1;
        cnt <= '0;
      end else if (cnt >= thr_m1) begin
        // >= keeps a lowered threshold from letting the count run past it.
        level     <= s;
        cnt       <= '0;
        rise_tick <= s;
        fall_tick <= ~s;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multi_edge_filter.sv
// CH independent glitch filters sharing enable and threshold.
module multi_edge_filter
  import edge_filter_pkg::*;
#(
  parameter int   CH          = 2,
  parameter int   CNT_W       = EF_CNT_W,
  parameter int   SYNC_STAGES = EF_SYNC_STAGES,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH-1:0]    d,
  input  logic             enable,
  input  logic [CNT_W-1:0] threshold,
  output logic [CH-1:0]    level,
  output logic [CH-1:0]    rise_tick,
  output logic [CH-1:0]    fall_tick,
  output logic [CH-1:0]    glitch_tick
);

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_filter_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .d           (d[i]),
      .enable      (enable),
      .threshold   (threshold),
      .level       (level[i]),
      .rise_tick   (rise_tick[i]),
      .fall_tick   (fall_tick[i]),
      .glitch_tick (glitch_tick[i])
    );
  end

endmodule

// File: doc/multi_edge_filter.md
Name: multi_edge_filter

Overview:
- Multi-channel glitch filter and edge detector for slow external lines such as I2C SCL and SDA.
- Each channel has its own synchronizer and its own stable-count debouncer.
- The debounce threshold is programmable at run time.
- Per channel, the block provides a filtered level, one-cycle rise/fall ticks, and a glitch-rejected tick.
- It sits between the pads and the protocol FSMs. Downstream logic consumes only `level` and the ticks, never raw `d`.

Parameters:
- `CH`, 2, number of independent channels.
- `CNT_W`, 4, width of the stable counter and of `threshold`. Maximum debounce is 2^CNT_W-1 cycles.
- `SYNC_STAGES`, 2, flip-flop stages in each input synchronizer. Legal values are 2 or more.
- `RESET_LEVEL`, 1'b1, value loaded into every channel's synchronizer and `level` on reset. 1 suits open-drain idle-high buses.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `d` input CH: raw asynchronous line inputs.
- `enable` input 1: when 0, filtering is frozen.
- `threshold` input CNT_W: stable cycles required before a level change. The value 0 is treated as 1.
- `level` output CH: filtered, registered line level.
- `rise_tick` output CH: one-cycle pulse in the cycle `level` goes 0->1.
- `fall_tick` output CH: one-cycle pulse in the cycle `level` goes 1->0.
- `glitch_tick` output CH: one-cycle pulse when a pending transition is abandoned.

Behaviour:
- Reset (synchronous, overrides everything):
  - all synchronizer stages <= RESET_LEVEL
  - `level` <= {CH{RESET_LEVEL}}
  - counters <= 0
  - all ticks <= 0
- Synchronizer:
  - `s[i]` is `d[i]` delayed by SYNC_STAGES flops.
  - It runs regardless of `enable`.
- Per channel, each edge with `enable`=1. Let `thr = (threshold==0) ? 1 : threshold`.
  - If `s==level` and `cnt!=0`: `cnt`<=0, `glitch_tick`<=1.
  - If `s==level` and `cnt==0`: no change.
  - If `s!=level` and `cnt >= thr-1`: `level`<=`s`, `cnt`<=0, and the matching rise/fall tick <=1.
  - If `s!=level` otherwise: `cnt`<=`cnt`+1.
  - Ticks are deasserted in every cycle not named above.
- Ticks are registered and coincide with the cycle in which `level` shows the new value.
  - At most one of rise/fall/glitch is asserted per channel per cycle.
- Latency: a clean input edge with `d` held stable produces the `level` change and tick SYNC_STAGES+thr edges after the first edge that samples the new `d`.
- Threshold changes mid-count:
  - The comparison always uses the current `threshold`, using `>=` so the count never overshoots.
  - Lowering `threshold` below a running `cnt` flips `level` on the next edge with `s!=level`.
  - `cnt` never exceeds 2^CNT_W-2, so there is no wrap-around.
- `enable`=0:
  - `level` holds.
  - `cnt`<=0 with no glitch pulse.
  - All ticks 0.
  - On re-enable, counting restarts from 0.
- Channels are fully independent. Simultaneous events on different channels each produce their own ticks in the same cycle.
- Reset mid-count discards the pending transition and produces no ticks. Ticks asserted when reset rises are cleared at that edge.

Decomposition:
- Package `edge_filter_pkg`:
  - default constants `EF_CNT_W=4` and `EF_SYNC_STAGES=2`
  - a typedef for the counter width
- Sub-module `edge_filter_chan`: one channel (synchronizer, counter, level, three ticks).
- `multi_edge_filter` instantiates `edge_filter_chan` CH times in a generate loop and broadcasts `enable`/`threshold`.

Test Plan:
All scenarios use CH=2, CNT_W=4, SYNC_STAGES=2, RESET_LEVEL=1, `threshold`=4, `enable`=1 unless stated.

- Reset check: assert `reset` for 2 cycles with `d`=2'b00 -> `level`=2'b11 and all ticks 0 during reset and the first cycle after.
- Clean fall: drive `d[0]` 1->0 and hold -> `fall_tick[0]` high for exactly 1 cycle, 6 edges after the first low sample. `level[0]`=0 from that cycle on. Channel 1 is unaffected.
- Glitch rejection: pulse `d[1]` low for 3 cycles -> no `fall_tick[1]`, `level[1]` stays 1, `glitch_tick[1]` pulses once. Repeat with 4 cycles -> `fall_tick[1]` fires, no glitch.
- `threshold`=0 and `threshold`=15: clean rise on `d[0]` -> `rise_tick[0]` at 3 edges and 17 edges respectively.
- Simultaneous events: `d`=2'b01 -> 2'b10, both held -> `rise_tick[1]` and `fall_tick[0]` in the same cycle.
- Mid-count interruptions:
  - drop `enable` after 2 counts -> no ticks, `level` held; re-enable -> full 4-cycle count restarts.
  - assert `reset` mid-count -> `level` returns to 1 with no tick.
